// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared core definitions used by the ROB, reservation stations, load/store
// buffer and the common data bus arbiter. It holds the ROB sizing, the
// CDB value width, default arbiter sizing, producer identifiers and a small
// modulo-increment helper.
// No ports (package).
package cdb_arbiter_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_TAG_W = $clog2(ROB_SIZE);
  localparam int CDB_VAL_W = 32;
  localparam int CDB_N_REQ = 4;
  localparam int CDB_DEPTH = 2;

  // Fixed requester slot assignment on the CDB.
  typedef enum logic [1:0] {
    PROD_ALU0   = 2'd0,
    PROD_ALU1   = 2'd1,
    PROD_LOAD   = 2'd2,
    PROD_BRANCH = 2'd3
  } producer_e;

  // Increment with wrap at an arbitrary (non power-of-two) modulus.
  function automatic int wrapInc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
// Per-requester holding FIFO for results waiting to win the CDB.
// Stores DEPTH entries of {tag, val}. Push and pop may happen on the same
// edge; flush empties the queue. The head entry is always visible.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   flush_i            empty the FIFO (lower priority than rst)
//   push_i, tag_i,     write one entry at the tail
//   val_i
//   pop_i              drop the head entry
//   count_o            number of valid entries (registered)
//   empty_o            count_o == 0
//   headTag_o,         contents of the head entry
//   headVal_o
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_DEPTH,
  parameter int TAG_W = ROB_TAG_W,
  parameter int VAL_W = CDB_VAL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic [VAL_W-1:0]           val_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic [TAG_W-1:0]           headTag_o,
  output logic [VAL_W-1:0]           headVal_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tagMem_q [DEPTH];
  logic [VAL_W-1:0] valMem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push_i) wrPtr_d = PTR_W'(wrapInc(int'(wrPtr_q), DEPTH));
    if (pop_i)  rdPtr_d = PTR_W'(wrapInc(int'(rdPtr_q), DEPTH));
    // Simultaneous push and pop leaves the count unchanged.
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i) begin
      tagMem_q[wrPtr_q] <= tag_i;
      valMem_q[wrPtr_q] <= val_i;
    end
  end

  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign headTag_o = tagMem_q[rdPtr_q];
  assign headVal_o = valMem_q[rdPtr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Two-port common data bus arbiter. Each of N_REQ result producers pushes
// into its own holding FIFO; every cycle up to two non-empty FIFOs are
// picked round-robin and their heads are registered onto CDB_1 / CDB_2.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   rdy                    global enable, low freezes all state
//   clear                  misprediction flush, empties everything
//   req_valid/tag/val      per-requester result (packed by requester)
//   req_ready              requester FIFO has room (no same-cycle credit)
//   CDB_x_ok/en/val        registered broadcast valid, ROB tag, value
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = CDB_N_REQ,
  parameter int DEPTH = CDB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         clear,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*TAG_W-1:0]       req_tag,
  input  logic [N_REQ*CDB_VAL_W-1:0]   req_val,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         CDB_1_ok,
  output logic [TAG_W-1:0]             CDB_1_en,
  output logic [CDB_VAL_W-1:0]         CDB_1_val,
  output logic                         CDB_2_ok,
  output logic [TAG_W-1:0]             CDB_2_en,
  output logic [CDB_VAL_W-1:0]         CDB_2_val
);

  localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [N_REQ-1:0]     fifoPush;
  logic [N_REQ-1:0]     fifoPop;
  logic [N_REQ-1:0]     fifoEmpty;
  logic [CNT_W-1:0]     fifoCount [N_REQ];
  logic [TAG_W-1:0]     headTag   [N_REQ];
  logic [CDB_VAL_W-1:0] headVal   [N_REQ];

  logic                 grantAValid, grantBValid;
  logic [RR_W-1:0]      grantAIdx, grantBIdx;
  logic [RR_W-1:0]      rrPtr_q, rrPtr_d;

  logic                 cdb1Ok_q, cdb2Ok_q;
  logic [TAG_W-1:0]     cdb1En_q, cdb2En_q;
  logic [CDB_VAL_W-1:0] cdb1Val_q, cdb2Val_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    // Ready depends only on the registered count, so a full FIFO stays
    // closed even on a cycle where its head is being broadcast.
    assign req_ready[g] = rdy && (fifoCount[g] < CNT_W'(DEPTH));
    assign fifoPush[g]  = req_valid[g] && req_ready[g] && !clear;

    cdb_fifo #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W),
      .VAL_W (CDB_VAL_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (clear),
      .push_i    (fifoPush[g]),
      .pop_i     (fifoPop[g]),
      .tag_i     (req_tag[g*TAG_W +: TAG_W]),
      .val_i     (req_val[g*CDB_VAL_W +: CDB_VAL_W]),
      .count_o   (fifoCount[g]),
      .empty_o   (fifoEmpty[g]),
      .headTag_o (headTag[g]),
      .headVal_o (headVal[g])
    );
  end

  // Grant A is the first non-empty FIFO scanning cyclically from rr;
  // grant B is the next non-empty one after A, never A itself.
  always_comb begin
    int idx;
    idx         = 0;
    grantAValid = 1'b0;
    grantAIdx   = '0;
    grantBValid = 1'b0;
    grantBIdx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grantAValid && !fifoEmpty[RR_W'(idx)]) begin
        grantAValid = 1'b1;
        grantAIdx   = RR_W'(idx);
      end
    end
    for (int k = 1; k < N_REQ; k++) begin
      idx = int'(grantAIdx) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (grantAValid && !grantBValid && !fifoEmpty[RR_W'(idx)]) begin
        grantBValid = 1'b1;
        grantBIdx   = RR_W'(idx);
      end
    end
  end

  // Pops only happen on edges that actually broadcast.
  always_comb begin
    fifoPop = '0;
    if (rdy && !clear) begin
      if (grantAValid) fifoPop[grantAIdx] = 1'b1;
      if (grantBValid) fifoPop[grantBIdx] = 1'b1;
    end
  end

  // Pointer moves just past the last granted requester.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grantAValid)
      rrPtr_d = RR_W'(wrapInc(int'(grantBValid ? grantBIdx : grantAIdx), N_REQ));
  end

  // Broadcast registers and round-robin pointer; rst beats clear beats rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q   <= '0;
      cdb1Ok_q  <= 1'b0;
      cdb1En_q  <= '0;
      cdb1Val_q <= '0;
      cdb2Ok_q  <= 1'b0;
      cdb2En_q  <= '0;
      cdb2Val_q <= '0;
    end else if (clear) begin
      rrPtr_q  <= '0;
      cdb1Ok_q <= 1'b0;
      cdb2Ok_q <= 1'b0;
    end else if (rdy) begin
      rrPtr_q  <= rrPtr_d;
      cdb1Ok_q <= grantAValid;
      cdb2Ok_q <= grantBValid;
      if (grantAValid) begin
        cdb1En_q  <= headTag[grantAIdx];
        cdb1Val_q <= headVal[grantAIdx];
      end
      if (grantBValid) begin
        cdb2En_q  <= headTag[grantBIdx];
        cdb2Val_q <= headVal[grantBIdx];
      end
    end
  end

  assign CDB_1_ok  = cdb1Ok_q;
  assign CDB_1_en  = cdb1En_q;
  assign CDB_1_val = cdb1Val_q;
  assign CDB_2_ok  = cdb2Ok_q;
  assign CDB_2_en  = cdb2En_q;
  assign CDB_2_val = cdb2Val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A queue-based reference model of the
// producers' FIFOs and the round-robin rule predicts readiness and both
// broadcast ports every cycle.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst, rdy, clear;
  logic [N-1:0]      req_valid;
  logic [N*TW-1:0]   req_tag;
  logic [N*32-1:0]   req_val;
  logic [N-1:0]      req_ready;
  logic              CDB_1_ok, CDB_2_ok;
  logic [TW-1:0]     CDB_1_en, CDB_2_en;
  logic [31:0]       CDB_1_val, CDB_2_val;

  logic [TW-1:0]     tagIn [N];
  logic [31:0]       valIn [N];

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   val;
  } ent_t;

  ent_t          mq [N][$];
  int            mrr;
  logic          expOk1, expOk2;
  logic [TW-1:0] expEn1, expEn2;
  logic [31:0]   expVal1, expVal2;
  logic [N-1:0]  expReady, readySampled;
  int            modelBc;

  int checkCount = 0;
  int passCount  = 0;

  cdb_arbiter #(.N_REQ(N), .DEPTH(D), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_val   (req_val),
    .req_ready (req_ready),
    .CDB_1_ok  (CDB_1_ok),
    .CDB_1_en  (CDB_1_en),
    .CDB_1_val (CDB_1_val),
    .CDB_2_ok  (CDB_2_ok),
    .CDB_2_en  (CDB_2_en),
    .CDB_2_val (CDB_2_val)
  );

  always #5 clk = ~clk;

  // Reference behaviour at one clock edge, using the inputs held over it.
  task automatic modelEdge();
    int order[$];
    logic [N-1:0] acc;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr = 0;
      expOk1 = 1'b0; expEn1 = '0; expVal1 = '0;
      expOk2 = 1'b0; expEn2 = '0; expVal2 = '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr = 0;
      expOk1 = 1'b0;
      expOk2 = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && (mq[i].size() < D);
      for (int k = 0; k < N; k++)
        if (mq[(mrr + k) % N].size() > 0) order.push_back((mrr + k) % N);
      expOk1 = (order.size() > 0);
      expOk2 = (order.size() > 1);
      if (expOk1) begin
        e = mq[order[0]].pop_front();
        expEn1 = e.tag; expVal1 = e.val;
        modelBc++;
      end
      if (expOk2) begin
        e = mq[order[1]].pop_front();
        expEn2 = e.tag; expVal2 = e.val;
        modelBc++;
      end
      if (expOk2) mrr = (order[1] + 1) % N;
      else if (expOk1) mrr = (order[0] + 1) % N;
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back('{tag: tagIn[i], val: valIn[i]});
    end
  endtask

  // Drive the current stimulus across one edge and advance the model.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW] = tagIn[i];
      req_val[i*32 +: 32] = valIn[i];
    end
    #1;
    readySampled = req_ready;
    for (int i = 0; i < N; i++) expReady[i] = rdy && (mq[i].size() < D);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; req_valid = '0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; req_valid = '1;
    for (int i = 0; i < N; i++) begin tagIn[i] = TW'(i + 1); valIn[i] = $urandom; end
    applyStimulus();
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0) $display("[TB] FAIL rst_ok1: got %0b want 0", CDB_1_ok); else passCount++;
    checkCount++; if (CDB_2_ok !== 1'b0) $display("[TB] FAIL rst_ok2: got %0b want 0", CDB_2_ok); else passCount++;
    checkCount++; if (CDB_1_en !== 4'h0) $display("[TB] FAIL rst_en1: got %0h want 0", CDB_1_en); else passCount++;
    checkCount++; if (CDB_2_en !== 4'h0) $display("[TB] FAIL rst_en2: got %0h want 0", CDB_2_en); else passCount++;
    checkCount++; if (CDB_1_val !== 32'h0) $display("[TB] FAIL rst_val1: got %0h want 0", CDB_1_val); else passCount++;
    checkCount++; if (CDB_2_val !== 32'h0) $display("[TB] FAIL rst_val2: got %0h want 0", CDB_2_val); else passCount++;
    checkCount++; if (readySampled !== 4'b1111) $display("[TB] FAIL rst_ready: got %b want 1111", readySampled); else passCount++;
    // Entries accepted just before a mid-run reset must vanish.
    rst = 1'b0; req_valid = 4'b0011;
    applyStimulus();
    rst = 1'b1; req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL rst_mid_ok: got %0b%0b want 00", CDB_1_ok, CDB_2_ok); else passCount++;
    rst = 1'b0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL rst_after_ok: got %0b%0b want 00", CDB_1_ok, CDB_2_ok); else passCount++;
  endtask

  task automatic test_single();
    resetDut();
    req_valid = 4'b0100; tagIn[2] = 4'd5; valIn[2] = 32'h1234;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0) $display("[TB] FAIL single_nobypass: got %0b want 0", CDB_1_ok); else passCount++;
    req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b1) $display("[TB] FAIL single_ok1: got %0b want 1", CDB_1_ok); else passCount++;
    checkCount++; if (CDB_1_en !== 4'd5) $display("[TB] FAIL single_en1: got %0h want 5", CDB_1_en); else passCount++;
    checkCount++; if (CDB_1_val !== 32'h1234) $display("[TB] FAIL single_val1: got %0h want 1234", CDB_1_val); else passCount++;
    checkCount++; if (CDB_2_ok !== 1'b0) $display("[TB] FAIL single_ok2: got %0b want 0", CDB_2_ok); else passCount++;
  endtask

  task automatic test_all_four();
    resetDut();
    req_valid = '1;
    for (int i = 0; i < N; i++) begin tagIn[i] = TW'(10 + i); valIn[i] = 32'h100 + i; end
    applyStimulus();
    req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd10 || CDB_1_val !== 32'h100)
      $display("[TB] FAIL all4_c1_port1: got ok=%0b en=%0d want ok=1 en=10", CDB_1_ok, CDB_1_en); else passCount++;
    checkCount++; if (CDB_2_ok !== 1'b1 || CDB_2_en !== 4'd11 || CDB_2_val !== 32'h101)
      $display("[TB] FAIL all4_c1_port2: got ok=%0b en=%0d want ok=1 en=11", CDB_2_ok, CDB_2_en); else passCount++;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd12)
      $display("[TB] FAIL all4_c2_port1: got ok=%0b en=%0d want ok=1 en=12", CDB_1_ok, CDB_1_en); else passCount++;
    checkCount++; if (CDB_2_ok !== 1'b1 || CDB_2_en !== 4'd13)
      $display("[TB] FAIL all4_c2_port2: got ok=%0b en=%0d want ok=1 en=13", CDB_2_ok, CDB_2_en); else passCount++;
    // rr back at 0 means requester 0 wins port 1 over requester 3.
    req_valid = 4'b1001; tagIn[0] = 4'd1; tagIn[3] = 4'd2;
    applyStimulus();
    req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_en !== 4'd1 || CDB_2_en !== 4'd2)
      $display("[TB] FAIL all4_rr0: got en1=%0d en2=%0d want 1 2", CDB_1_en, CDB_2_en); else passCount++;
  endtask

  task automatic test_backpressure();
    int pend[$];
    int seen[$];
    bit sawStall;
    int accepts;
    resetDut();
    pend = '{1, 2, 3};
    sawStall = 1'b0;
    accepts = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int i = 1; i < N; i++) begin
        tagIn[i] = TW'(8 + i);
        valIn[i] = 32'hA000_0000 | (i << 8) | cyc;
      end
      req_valid[3:1] = '1;
      req_valid[0] = (cyc >= 2) && (pend.size() > 0);
      if (pend.size() > 0) begin tagIn[0] = TW'(pend[0]); valIn[0] = 32'hB000_0000 | pend[0]; end
      applyStimulus();
      if (req_valid[0] && readySampled[0]) begin void'(pend.pop_front()); accepts++; end
      else if (req_valid[0] && accepts == 2) sawStall = 1'b1;
      checkCount++; if (readySampled !== expReady)
        $display("[TB] FAIL bp_ready c%0d: got %b want %b", cyc, readySampled, expReady); else passCount++;
      checkCount++; if (CDB_1_ok !== expOk1 || CDB_2_ok !== expOk2)
        $display("[TB] FAIL bp_ok c%0d: got %0b%0b want %0b%0b", cyc, CDB_1_ok, CDB_2_ok, expOk1, expOk2); else passCount++;
      if (CDB_1_ok && CDB_1_val[31:28] == 4'hB) seen.push_back(int'(CDB_1_en));
      if (CDB_2_ok && CDB_2_val[31:28] == 4'hB) seen.push_back(int'(CDB_2_en));
    end
    req_valid = '0;
    checkCount++; if (!sawStall) $display("[TB] FAIL bp_stall: got no stall want ready0=0 after 2 accepts"); else passCount++;
    checkCount++; if (accepts != 3) $display("[TB] FAIL bp_accepts: got %0d want 3", accepts); else passCount++;
    checkCount++; if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3)
      $display("[TB] FAIL bp_order: got %p want 1 2 3", seen); else passCount++;
  endtask

  task automatic test_clear();
    resetDut();
    req_valid = 4'b0111;
    for (int i = 0; i < N; i++) begin tagIn[i] = TW'(i + 1); valIn[i] = 32'hC0 + i; end
    applyStimulus();
    clear = 1'b1; req_valid = 4'b1000; tagIn[3] = 4'd4;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL clr_ok: got %0b%0b want 00", CDB_1_ok, CDB_2_ok); else passCount++;
    clear = 1'b0; req_valid = '0;
    applyStimulus();
    checkCount++; if (readySampled !== 4'b1111) $display("[TB] FAIL clr_ready: got %b want 1111", readySampled); else passCount++;
    checkCount++; if (CDB_1_ok !== 1'b0 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL clr_empty: got %0b%0b want 00", CDB_1_ok, CDB_2_ok); else passCount++;
    req_valid = 4'b0010; tagIn[1] = 4'd9; valIn[1] = 32'h99;
    applyStimulus();
    req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd9 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL clr_tag9: got ok1=%0b en1=%0d ok2=%0b want 1 9 0", CDB_1_ok, CDB_1_en, CDB_2_ok); else passCount++;
  endtask

  task automatic test_rdy_low();
    resetDut();
    req_valid = 4'b0111;
    tagIn[0] = 4'd7; valIn[0] = 32'h70;
    tagIn[1] = 4'd4; valIn[1] = 32'h40;
    tagIn[2] = 4'd6; valIn[2] = 32'h60;
    applyStimulus();
    req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_en !== 4'd7 || CDB_2_en !== 4'd4)
      $display("[TB] FAIL rdy_setup: got en1=%0d en2=%0d want 7 4", CDB_1_en, CDB_2_en); else passCount++;
    rdy = 1'b0; req_valid = 4'b1000; tagIn[3] = 4'hE;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkCount++; if (readySampled !== 4'b0000) $display("[TB] FAIL rdy_ready c%0d: got %b want 0000", c, readySampled); else passCount++;
      checkCount++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd7 || CDB_1_val !== 32'h70)
        $display("[TB] FAIL rdy_frz1 c%0d: got ok=%0b en=%0d want 1 7", c, CDB_1_ok, CDB_1_en); else passCount++;
      checkCount++; if (CDB_2_ok !== 1'b1 || CDB_2_en !== 4'd4)
        $display("[TB] FAIL rdy_frz2 c%0d: got ok=%0b en=%0d want 1 4", c, CDB_2_ok, CDB_2_en); else passCount++;
    end
    rdy = 1'b1; req_valid = '0;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd6 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL rdy_resume: got ok1=%0b en1=%0d ok2=%0b want 1 6 0", CDB_1_ok, CDB_1_en, CDB_2_ok); else passCount++;
    applyStimulus();
    checkCount++; if (CDB_1_ok !== 1'b0) $display("[TB] FAIL rdy_nopush: got %0b want 0", CDB_1_ok); else passCount++;
  endtask

  task automatic test_stress();
    int dutBc;
    resetDut();
    modelBc = 0;
    dutBc = 0;
    for (int cyc = 0; cyc < 820; cyc++) begin
      if (cyc < 800) begin
        rst   = ($urandom_range(0, 99) == 0);
        clear = ($urandom_range(0, 39) == 0);
        rdy   = ($urandom_range(0, 9) != 0);
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin tagIn[i] = TW'($urandom); valIn[i] = $urandom; end
      end else begin
        rst = 1'b0; clear = 1'b0; rdy = 1'b1; req_valid = '0;
      end
      applyStimulus();
      if (!rst && !clear && rdy) dutBc += int'(CDB_1_ok) + int'(CDB_2_ok);
      checkCount++; if (readySampled !== expReady)
        $display("[TB] FAIL st_ready c%0d: got %b want %b", cyc, readySampled, expReady); else passCount++;
      checkCount++; if (CDB_1_ok !== expOk1 || (expOk1 && (CDB_1_en !== expEn1 || CDB_1_val !== expVal1)))
        $display("[TB] FAIL st_port1 c%0d: got %0b/%0h/%0h want %0b/%0h/%0h", cyc,
                 CDB_1_ok, CDB_1_en, CDB_1_val, expOk1, expEn1, expVal1); else passCount++;
      checkCount++; if (CDB_2_ok !== expOk2 || (expOk2 && (CDB_2_en !== expEn2 || CDB_2_val !== expVal2)))
        $display("[TB] FAIL st_port2 c%0d: got %0b/%0h/%0h want %0b/%0h/%0h", cyc,
                 CDB_2_ok, CDB_2_en, CDB_2_val, expOk2, expEn2, expVal2); else passCount++;
    end
    checkCount++; if (dutBc != modelBc) $display("[TB] FAIL st_count: got %0d broadcasts want %0d", dutBc, modelBc); else passCount++;
    checkCount++; if (CDB_1_ok !== 1'b0 || CDB_2_ok !== 1'b0)
      $display("[TB] FAIL st_drained: got %0b%0b want 00", CDB_1_ok, CDB_2_ok); else passCount++;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; req_valid = '0;
    req_tag = '0; req_val = '0;
    for (int i = 0; i < N; i++) begin tagIn[i] = '0; valIn[i] = '0; end
    mrr = 0; modelBc = 0;
    expOk1 = 1'b0; expOk2 = 1'b0; expEn1 = '0; expEn2 = '0; expVal1 = '0; expVal2 = '0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_clear();
    test_rdy_low();
    test_stress();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
